// File: rtl/fixed_point_divider_if.sv
// Start/busy/ready handshake bundle between an FDIV issuer (master) and the
// sequential fixed-point divider (slave).
interface fixed_point_divider_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic [WIDTH-1:0] i_operand_1;
    logic [WIDTH-1:0] i_operand_2;
    logic [WIDTH-1:0] o_result;
    logic             o_busy;
    logic             o_ready;
    logic             o_div_by_zero;
    logic             o_overflow;

    modport master (
        output i_start, i_operand_1, i_operand_2,
        input  o_result, o_busy, o_ready, o_div_by_zero, o_overflow
    );

    modport slave (
        input  i_start, i_operand_1, i_operand_2,
        output o_result, o_busy, o_ready, o_div_by_zero, o_overflow
    );
endinterface

// File: rtl/fixed_point_divider.sv
// Signed Q(WIDTH-FBITS-1).FBITS divider, radix-2 restoring, one quotient bit per clock.
// Optional FIXED_POINT_DIVIDER_ROUND_EN: round half away from zero instead of truncating.
module fixed_point_divider #(
    parameter int WIDTH = 32,
    parameter int FBITS = 10
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    fixed_point_divider_if.slave div_if
);
    localparam int NW = WIDTH + FBITS;
    localparam int CW = $clog2(NW + 1);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [NW:0]      POS_LIM = {{(FBITS+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [NW:0]      NEG_LIM = {{(FBITS+1){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_ready, w_ready_nxt;
    logic             r_dz, w_dz_nxt;
    logic             r_ovf, w_ovf_nxt;

    logic [WIDTH-1:0] r_op1, w_op1_nxt;
    logic [WIDTH-1:0] r_op2, w_op2_nxt;
    logic             r_sign, w_sign_nxt;
    logic [WIDTH-1:0] r_dmag, w_dmag_nxt;
    logic [NW-1:0]    r_numer, w_numer_nxt;
    logic [WIDTH-1:0] r_rem, w_rem_nxt;
    logic [NW-1:0]    r_quot, w_quot_nxt;
    logic [CW-1:0]    r_count, w_count_nxt;

    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic [WIDTH:0]   w_rem_shift;
    logic             w_rem_ge;
    logic [WIDTH-1:0] w_rem_sub;
    logic [NW:0]      w_mag_fix;
    logic             w_ovf_fix;
    logic [WIDTH-1:0] w_mag_lo;

    assign w_mag1 = r_op1[WIDTH-1] ? -r_op1 : r_op1;
    assign w_mag2 = r_op2[WIDTH-1] ? -r_op2 : r_op2;

    // The settled remainder is always below |op2| <= 2^(WIDTH-1), so WIDTH bits
    // hold it; only the shifted trial value needs the extra bit.
    assign w_rem_shift = {r_rem, r_numer[NW-1]};
    assign w_rem_ge    = w_rem_shift >= {1'b0, r_dmag};
    assign w_rem_sub   = w_rem_shift[WIDTH-1:0] - r_dmag;

`ifdef FIXED_POINT_DIVIDER_ROUND_EN
    logic w_round_up;
    assign w_round_up = {r_rem, 1'b0} >= {1'b0, r_dmag};
    assign w_mag_fix  = {1'b0, r_quot} + {{NW{1'b0}}, w_round_up};
`else
    assign w_mag_fix  = {1'b0, r_quot};
`endif

    assign w_ovf_fix = r_sign ? (w_mag_fix > NEG_LIM) : (w_mag_fix > POS_LIM);
    assign w_mag_lo  = w_mag_fix[WIDTH-1:0];

    // NOTE: every signal gets a default before the case so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_result_nxt = r_result;
        w_busy_nxt   = r_busy;
        w_ready_nxt  = 1'b0;
        w_dz_nxt     = r_dz;
        w_ovf_nxt    = r_ovf;
        w_op1_nxt    = r_op1;
        w_op2_nxt    = r_op2;
        w_sign_nxt   = r_sign;
        w_dmag_nxt   = r_dmag;
        w_numer_nxt  = r_numer;
        w_rem_nxt    = r_rem;
        w_quot_nxt   = r_quot;
        w_count_nxt  = r_count;

        case (r_state)
            S_IDLE: begin
                if (div_if.i_start) begin
                    w_op1_nxt   = div_if.i_operand_1;
                    w_op2_nxt   = div_if.i_operand_2;
                    w_dz_nxt    = 1'b0;
                    w_ovf_nxt   = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_PREP;
                end
            end

            S_PREP: begin
                w_sign_nxt  = r_op1[WIDTH-1] ^ r_op2[WIDTH-1];
                w_dmag_nxt  = w_mag2;
                w_numer_nxt = {w_mag1, {FBITS{1'b0}}};
                w_rem_nxt   = '0;
                w_quot_nxt  = '0;
                w_count_nxt = CW'(NW);
                if (r_op2 == '0) begin
                    w_result_nxt = r_op1[WIDTH-1] ? MIN_NEG : MAX_POS;
                    w_dz_nxt     = 1'b1;
                    w_ready_nxt  = 1'b1;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_state_nxt = S_ITER;
                end
            end

            S_ITER: begin
                w_numer_nxt = {r_numer[NW-2:0], 1'b0};
                w_rem_nxt   = w_rem_ge ? w_rem_sub : w_rem_shift[WIDTH-1:0];
                w_quot_nxt  = {r_quot[NW-2:0], w_rem_ge};
                w_count_nxt = r_count - CW'(1);
                if (r_count == CW'(1)) begin
                    w_state_nxt = S_FIX;
                end
            end

            S_FIX: begin
                w_ovf_nxt = w_ovf_fix;
                if (w_ovf_fix) begin
                    w_result_nxt = r_sign ? MIN_NEG : MAX_POS;
                end else begin
                    w_result_nxt = r_sign ? -w_mag_lo : w_mag_lo;
                end
                w_ready_nxt = 1'b1;
                w_state_nxt = S_DONE;
            end

            S_DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_result <= w_result_nxt;
            r_busy   <= w_busy_nxt;
            r_ready  <= w_ready_nxt;
            r_dz     <= w_dz_nxt;
            r_ovf    <= w_ovf_nxt;
        end
    end

    // NOTE: datapath registers are left unreset; PREP reloads them before any use.
    always_ff @(posedge i_clk) begin
        r_op1   <= w_op1_nxt;
        r_op2   <= w_op2_nxt;
        r_sign  <= w_sign_nxt;
        r_dmag  <= w_dmag_nxt;
        r_numer <= w_numer_nxt;
        r_rem   <= w_rem_nxt;
        r_quot  <= w_quot_nxt;
        r_count <= w_count_nxt;
    end

    assign div_if.o_result      = r_result;
    assign div_if.o_busy        = r_busy;
    assign div_if.o_ready       = r_ready;
    assign div_if.o_div_by_zero = r_dz;
    assign div_if.o_overflow    = r_ovf;
endmodule
